// File: rtl/axo_mem_arbiter.sv
// rtl/axo_mem_arbiter.sv - round-robin arbiter sharing one memory slave among NPORTS masters
// Optional feature: define AXO_ARB_TIMEOUT_EN to abort transactions stuck in BUSY after TIMEOUT cycles.
module axo_mem_arbiter #(
    parameter int              NPORTS       = 2,
    parameter int              AW           = 32,
    parameter int              DW           = 32,
    parameter int              TIMEOUT      = 255,
    parameter logic [DW-1:0]   TIMEOUT_CODE = DW'(32'h0000_00FF)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NPORTS-1:0]      req_re,
    input  logic [NPORTS-1:0]      req_we,
    input  logic [2*NPORTS-1:0]    req_asize,
    input  logic [AW*NPORTS-1:0]   req_addr,
    input  logic [DW*NPORTS-1:0]   req_wdata,
    output logic [DW*NPORTS-1:0]   req_rdata,
    output logic [NPORTS-1:0]      req_ready,
    output logic [NPORTS-1:0]      req_error,
    output logic                   mem_re,
    output logic                   mem_we,
    output logic [1:0]             mem_asize,
    output logic [AW-1:0]          mem_addr,
    output logic [DW-1:0]          mem_wdata,
    input  logic [DW-1:0]          mem_rdata,
    input  logic                   mem_ready,
    input  logic                   mem_error,
    output logic [NPORTS-1:0]      grant,
    output logic                   busy
);

    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    typedef enum logic {IDLE, BUSY} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] owner_q, owner_d;
    logic [PW-1:0] rr_q, rr_d;
    logic          tmo_hit;
    logic          own_req;
    logic          found;
    int            oi;
    int            cand;

`ifdef AXO_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [CW-1:0] tmo_q, tmo_d;

    // Count stalled BUSY cycles; IDLE clears it so every transaction starts from zero.
    always_comb begin
        tmo_d = tmo_q;
        if (state_q == IDLE) begin
            tmo_d = '0;
        end else if (!mem_ready && (tmo_q != CW'(TIMEOUT))) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    // Timeout counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    // A real completion in the same cycle takes priority over the abort.
    assign tmo_hit = (state_q == BUSY) && (tmo_q == CW'(TIMEOUT)) && !mem_ready;
`else
    assign tmo_hit = 1'b0;
`endif

    // Next-state: round-robin pick in IDLE; completion, timeout or owner drop ends BUSY.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        found   = 1'b0;
        cand    = 0;
        own_req = req_re[owner_q] | req_we[owner_q];
        case (state_q)
            IDLE: begin
                for (int k = 0; k < NPORTS; k++) begin
                    cand = (int'(rr_q) + k) % NPORTS;
                    if (!found && (req_re[cand] | req_we[cand])) begin
                        found   = 1'b1;
                        owner_d = PW'(cand);
                    end
                end
                if (found) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (mem_ready || tmo_hit) begin
                    rr_d    = PW'((int'(owner_q) + 1) % NPORTS);
                    state_d = IDLE;
                end else if (!own_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
        end
    end

    // Route the owner's request to the slave and the slave's response back to the owner only.
    always_comb begin
        oi        = int'(owner_q);
        grant     = '0;
        busy      = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_asize = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        req_rdata = '0;
        req_ready = '0;
        req_error = '0;
        if (state_q == BUSY) begin
            busy                   = 1'b1;
            grant[oi]              = 1'b1;
            mem_re                 = req_re[oi] & ~tmo_hit;
            mem_we                 = req_we[oi] & ~tmo_hit;
            mem_asize              = req_asize[oi*2 +: 2];
            mem_addr               = req_addr[oi*AW +: AW];
            mem_wdata              = req_wdata[oi*DW +: DW];
            req_rdata[oi*DW +: DW] = tmo_hit ? TIMEOUT_CODE : mem_rdata;
            req_ready[oi]          = mem_ready | tmo_hit;
            req_error[oi]          = mem_error | tmo_hit;
        end
    end

endmodule
